// File: rtl/nmc_initiator.sv
// nmc_initiator: host-side initiator for the nmc near-memory block.
// Accepts WRITE / QUERY / FLUSH commands, pushes requests into the nmc FIFOs,
// tags every query response and buffers it for a valid/ready consumer.
// A WRITE is fenced until every issued query has returned, because nmc
// services writes ahead of queued queries.
// Optional feature: define NMC_INITIATOR_STATS_EN to build saturating
// hit/miss counters; otherwise hit_cnt/miss_cnt are tied to zero.

package nmc_pkg;
    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 16;
    localparam int KEY_W    = 16;
    localparam int RESULT_W = 16;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } nmc_wr_req_t;

    typedef struct packed {
        logic [KEY_W-1:0] key;
    } nmc_qr_req_t;

    typedef struct packed {
        logic                valid;
        logic                found;
        logic [RESULT_W-1:0] result;
    } nmc_qr_resp_t;
endpackage

module nmc_initiator
    import nmc_pkg::*;
#(
    parameter int TAG_W           = 4,
    parameter int RESP_FIFO_DEPTH = 8,
    parameter int CNT_W           = 32
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               cmd_vld,
    output logic                               cmd_rdy,
    input  logic [1:0]                         cmd_op,
    input  logic [$bits(nmc_wr_req_t)-1:0]     cmd_wr,
    input  logic [$bits(nmc_qr_req_t)-1:0]     cmd_qr,
    input  logic [TAG_W-1:0]                   cmd_tag,
    output logic [$bits(nmc_wr_req_t)-1:0]     nmc_wr_req,
    output logic                               nwr_push,
    input  logic                               nwr_full,
    output logic [$bits(nmc_qr_req_t)-1:0]     nmc_qr_req,
    output logic                               nqr_push,
    input  logic                               nqr_full,
    input  logic                               nmc_ready,
    input  logic [$bits(nmc_qr_resp_t)-1:0]    nmc_qr_resp,
    output logic                               resp_vld,
    input  logic                               resp_rdy,
    output logic                               resp_found,
    output logic [RESULT_W-1:0]                resp_result,
    output logic [TAG_W-1:0]                   resp_tag,
    output logic                               flush_done,
    output logic                               err_unexp,
    output logic [CNT_W-1:0]                   hit_cnt,
    output logic [CNT_W-1:0]                   miss_cnt
);

    localparam int PTR_W = $clog2(RESP_FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int ENT_W = 1 + RESULT_W + TAG_W;

    localparam logic [OCC_W-1:0] OCC_ONE    = OCC_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [OCC_W:0]   CREDIT_LIM = (OCC_W+1)'(RESP_FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_FENCE = 3'd1,
        ST_WR_PUSH  = 3'd2,
        ST_QR_PUSH  = 3'd3,
        ST_FLUSH    = 3'd4
    } state_t;

    state_t             state_r;
    logic               cmd_rdy_r;
    logic               flush_done_r;
    logic               err_unexp_r;
    nmc_wr_req_t        cmd_wr_r;
    nmc_qr_req_t        cmd_qr_r;
    logic [TAG_W-1:0]   cmd_tag_r;

    logic [OCC_W-1:0]   outstanding_r;
    logic [TAG_W-1:0]   tag_mem [RESP_FIFO_DEPTH];
    logic [PTR_W-1:0]   tag_wr_ptr_r;
    logic [PTR_W-1:0]   tag_rd_ptr_r;

    logic [ENT_W-1:0]   rsp_mem [RESP_FIFO_DEPTH];
    logic [PTR_W-1:0]   rsp_wr_ptr_r;
    logic [PTR_W-1:0]   rsp_rd_ptr_r;
    logic [OCC_W-1:0]   rsp_cnt_r;

    nmc_qr_resp_t       resp_in_s;
    logic               accept_s;
    logic               wr_push_s;
    logic               qr_push_s;
    logic               credit_ok_s;
    logic [OCC_W:0]     credit_sum_s;
    logic               rsp_take_s;
    logic               rsp_unexp_s;
    logic               rsp_pop_s;
    logic [OCC_W-1:0]   outstanding_nxt_s;
    logic               flush_ok_s;
    logic [ENT_W-1:0]   rsp_head_s;

    assign resp_in_s = nmc_qr_resp;

    // Push qualification, response capture decisions and outstanding look-ahead
    always_comb begin
        accept_s     = cmd_vld && cmd_rdy_r;
        credit_sum_s = {1'b0, outstanding_r} + {1'b0, rsp_cnt_r};
        // Queries in flight plus buffered responses never exceed the buffer,
        // so the capture path can never find the response FIFO full.
        credit_ok_s  = (credit_sum_s < CREDIT_LIM);

        wr_push_s = 1'b0;
        if (state_r == ST_WR_FENCE) begin
            wr_push_s = (outstanding_r == '0) && !nwr_full;
        end else if (state_r == ST_WR_PUSH) begin
            wr_push_s = !nwr_full;
        end else begin
            wr_push_s = 1'b0;
        end

        qr_push_s   = (state_r == ST_QR_PUSH) && !nqr_full && credit_ok_s;
        rsp_take_s  = resp_in_s.valid && (outstanding_r != '0);
        rsp_unexp_s = resp_in_s.valid && (outstanding_r == '0);
        rsp_pop_s   = (rsp_cnt_r != '0) && resp_rdy;

        outstanding_nxt_s = outstanding_r;
        if (qr_push_s && !rsp_take_s) begin
            outstanding_nxt_s = outstanding_r + OCC_ONE;
        end else if (!qr_push_s && rsp_take_s) begin
            outstanding_nxt_s = outstanding_r - OCC_ONE;
        end else begin
            outstanding_nxt_s = outstanding_r;
        end

        // Only one command is in service at a time, so no write can be
        // pending while a FLUSH waits; completion needs nmc drained and idle.
        flush_ok_s = (outstanding_nxt_s == '0) && nmc_ready;
    end

    // Command FSM: acceptance, command register, write fence and flush completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cmd_rdy_r    <= 1'b0;
            flush_done_r <= 1'b0;
            cmd_wr_r     <= '0;
            cmd_qr_r     <= '0;
            cmd_tag_r    <= '0;
        end else begin
            flush_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        cmd_wr_r  <= cmd_wr;
                        cmd_qr_r  <= cmd_qr;
                        cmd_tag_r <= cmd_tag;
                        case (cmd_op)
                            2'd0: begin
                                state_r   <= ST_WR_FENCE;
                                cmd_rdy_r <= 1'b0;
                            end
                            2'd1: begin
                                state_r   <= ST_QR_PUSH;
                                cmd_rdy_r <= 1'b0;
                            end
                            2'd2: begin
                                state_r   <= ST_FLUSH;
                                cmd_rdy_r <= 1'b0;
                            end
                            default: begin
                                state_r   <= ST_IDLE;
                                cmd_rdy_r <= 1'b1;
                            end
                        endcase
                    end else begin
                        cmd_rdy_r <= 1'b1;
                    end
                end
                ST_WR_FENCE: begin
                    if (wr_push_s) begin
                        state_r   <= ST_IDLE;
                        cmd_rdy_r <= 1'b1;
                    end else if (outstanding_r == '0) begin
                        state_r <= ST_WR_PUSH;
                    end
                end
                ST_WR_PUSH: begin
                    if (wr_push_s) begin
                        state_r   <= ST_IDLE;
                        cmd_rdy_r <= 1'b1;
                    end
                end
                ST_QR_PUSH: begin
                    if (qr_push_s) begin
                        state_r   <= ST_IDLE;
                        cmd_rdy_r <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (flush_ok_s) begin
                        state_r      <= ST_IDLE;
                        cmd_rdy_r    <= 1'b1;
                        flush_done_r <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    cmd_rdy_r <= 1'b1;
                end
            endcase
        end
    end

    // Outstanding count, FIFO pointers/occupancy and sticky unexpected-response flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding_r <= '0;
            tag_wr_ptr_r  <= '0;
            tag_rd_ptr_r  <= '0;
            rsp_wr_ptr_r  <= '0;
            rsp_rd_ptr_r  <= '0;
            rsp_cnt_r     <= '0;
            err_unexp_r   <= 1'b0;
        end else begin
            outstanding_r <= outstanding_nxt_s;
            if (qr_push_s) begin
                tag_wr_ptr_r <= tag_wr_ptr_r + PTR_ONE;
            end
            if (rsp_take_s) begin
                tag_rd_ptr_r <= tag_rd_ptr_r + PTR_ONE;
                rsp_wr_ptr_r <= rsp_wr_ptr_r + PTR_ONE;
            end
            if (rsp_pop_s) begin
                rsp_rd_ptr_r <= rsp_rd_ptr_r + PTR_ONE;
            end
            if (rsp_take_s && !rsp_pop_s) begin
                rsp_cnt_r <= rsp_cnt_r + OCC_ONE;
            end else if (!rsp_take_s && rsp_pop_s) begin
                rsp_cnt_r <= rsp_cnt_r - OCC_ONE;
            end
            if (rsp_unexp_s) begin
                err_unexp_r <= 1'b1;
            end
        end
    end

    // Tag and response storage arrays (data only; validity tracked by pointers)
    always_ff @(posedge clk) begin
        if (qr_push_s) begin
            tag_mem[tag_wr_ptr_r] <= cmd_tag_r;
        end
        if (rsp_take_s) begin
            rsp_mem[rsp_wr_ptr_r] <= {resp_in_s.found, resp_in_s.result, tag_mem[tag_rd_ptr_r]};
        end
    end

    assign rsp_head_s  = rsp_mem[rsp_rd_ptr_r];
    assign resp_vld    = (rsp_cnt_r != '0);
    assign resp_found  = rsp_head_s[ENT_W-1];
    assign resp_result = rsp_head_s[ENT_W-2 -: RESULT_W];
    assign resp_tag    = rsp_head_s[TAG_W-1:0];

    assign cmd_rdy     = cmd_rdy_r;
    assign nwr_push    = wr_push_s;
    assign nqr_push    = qr_push_s;
    assign nmc_wr_req  = cmd_wr_r;
    assign nmc_qr_req  = cmd_qr_r;
    assign flush_done  = flush_done_r;
    assign err_unexp   = err_unexp_r;

`ifdef NMC_INITIATOR_STATS_EN
    logic [CNT_W-1:0] hit_cnt_r;
    logic [CNT_W-1:0] miss_cnt_r;

    // Saturating hit/miss counters over captured (expected) responses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_r  <= '0;
            miss_cnt_r <= '0;
        end else if (rsp_take_s) begin
            if (resp_in_s.found) begin
                if (hit_cnt_r != '1) begin
                    hit_cnt_r <= hit_cnt_r + CNT_W'(1);
                end
            end else begin
                if (miss_cnt_r != '1) begin
                    miss_cnt_r <= miss_cnt_r + CNT_W'(1);
                end
            end
        end
    end

    assign hit_cnt  = hit_cnt_r;
    assign miss_cnt = miss_cnt_r;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_nmc_initiator.sv
// Directed self-checking bench for nmc_initiator.
module tb_nmc_initiator;
    import nmc_pkg::*;

    localparam int TAG_W = 4;
    localparam int DEPTH = 8;
    localparam int CNT_W = 32;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cmd_vld = 1'b0;
    logic               cmd_rdy;
    logic [1:0]         cmd_op = 2'd0;
    nmc_wr_req_t        cmd_wr = '0;
    nmc_qr_req_t        cmd_qr = '0;
    logic [TAG_W-1:0]   cmd_tag = '0;
    nmc_wr_req_t        nmc_wr_req;
    logic               nwr_push;
    logic               nwr_full = 1'b0;
    nmc_qr_req_t        nmc_qr_req;
    logic               nqr_push;
    logic               nqr_full = 1'b0;
    logic               nmc_ready = 1'b1;
    nmc_qr_resp_t       nmc_qr_resp = '0;
    logic               resp_vld;
    logic               resp_rdy = 1'b0;
    logic               resp_found;
    logic [RESULT_W-1:0] resp_result;
    logic [TAG_W-1:0]   resp_tag;
    logic               flush_done;
    logic               err_unexp;
    logic [CNT_W-1:0]   hit_cnt;
    logic [CNT_W-1:0]   miss_cnt;

    int checks = 0;
    int failures = 0;
    logic [CNT_W-1:0] exp_hit = '0;
    logic [CNT_W-1:0] exp_miss = '0;

    nmc_initiator #(.TAG_W(TAG_W), .RESP_FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_op(cmd_op),
        .cmd_wr(cmd_wr), .cmd_qr(cmd_qr), .cmd_tag(cmd_tag),
        .nmc_wr_req(nmc_wr_req), .nwr_push(nwr_push), .nwr_full(nwr_full),
        .nmc_qr_req(nmc_qr_req), .nqr_push(nqr_push), .nqr_full(nqr_full),
        .nmc_ready(nmc_ready), .nmc_qr_resp(nmc_qr_resp),
        .resp_vld(resp_vld), .resp_rdy(resp_rdy), .resp_found(resp_found),
        .resp_result(resp_result), .resp_tag(resp_tag),
        .flush_done(flush_done), .err_unexp(err_unexp),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    // Counter values the DUT should show given the responses captured so far
    function automatic logic [CNT_W-1:0] stat_exp(input logic [CNT_W-1:0] v);
`ifdef NMC_INITIATOR_STATS_EN
        return v;
`else
        return '0;
`endif
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Present one command once cmd_rdy is high; returns 1 ns into the cycle after acceptance
    task automatic issue(input logic [1:0] op, input logic [7:0] addr,
                         input logic [15:0] key, input logic [TAG_W-1:0] tag);
        int n;
        n = 0;
        while (cmd_rdy !== 1'b1 && n < 40) begin
            cycle();
            n++;
        end
        if (cmd_rdy !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL issue_rdy_timeout cmd_rdy=%b expected=1", cmd_rdy);
        end
        cmd_vld = 1'b1;
        cmd_op = op;
        cmd_wr.addr = addr;
        cmd_wr.data = {8'hA5, addr};
        cmd_qr.key = key;
        cmd_tag = tag;
        cycle();
        cmd_vld = 1'b0;
        #1;
    endtask

    // Single-cycle response pulse from nmc
    task automatic pulse_resp(input logic found, input logic [RESULT_W-1:0] result);
        nmc_qr_resp.valid = 1'b1;
        nmc_qr_resp.found = found;
        nmc_qr_resp.result = result;
        cycle();
        nmc_qr_resp = '0;
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({cmd_rdy, nwr_push, nqr_push, resp_vld, flush_done, err_unexp} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b expected=000000",
                     {cmd_rdy, nwr_push, nqr_push, resp_vld, flush_done, err_unexp});
        end
        checks++;
        if (hit_cnt !== '0 || miss_cnt !== '0) begin
            failures++;
            $display("FAIL reset_counters hit=%0d miss=%0d expected=0/0", hit_cnt, miss_cnt);
        end
        cycle();
        #2;
        rst_n = 1'b1;
        cycle();
        checks++;
        if (cmd_rdy !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_rdy got=%b expected=1", cmd_rdy);
        end
    endtask

    task automatic test_write();
        issue(2'd0, 8'd3, 16'h0, 4'd0);
        checks++;
        if (nwr_push !== 1'b1 || nmc_wr_req.addr !== 8'd3 || cmd_rdy !== 1'b0) begin
            failures++;
            $display("FAIL write_push push=%b addr=%0d rdy=%b expected=1/3/0",
                     nwr_push, nmc_wr_req.addr, cmd_rdy);
        end
        cycle();
        checks++;
        if (nwr_push !== 1'b0 || cmd_rdy !== 1'b1) begin
            failures++;
            $display("FAIL write_after push=%b rdy=%b expected=0/1", nwr_push, cmd_rdy);
        end
        // Full FIFO stalls the push until it drains
        nwr_full = 1'b1;
        issue(2'd0, 8'd4, 16'h0, 4'd0);
        checks++;
        if (nwr_push !== 1'b0) begin
            failures++;
            $display("FAIL write_full_stall0 push=%b expected=0", nwr_push);
        end
        cycle();
        checks++;
        if (nwr_push !== 1'b0) begin
            failures++;
            $display("FAIL write_full_stall1 push=%b expected=0", nwr_push);
        end
        nwr_full = 1'b0;
        #1;
        checks++;
        if (nwr_push !== 1'b1 || nmc_wr_req.addr !== 8'd4 || nmc_wr_req.data !== 16'hA504) begin
            failures++;
            $display("FAIL write_full_release push=%b addr=%0d data=%h expected=1/4/a504",
                     nwr_push, nmc_wr_req.addr, nmc_wr_req.data);
        end
        cycle();
        checks++;
        if (nwr_push !== 1'b0 || cmd_rdy !== 1'b1) begin
            failures++;
            $display("FAIL write_full_after push=%b rdy=%b expected=0/1", nwr_push, cmd_rdy);
        end
    endtask

    task automatic test_query_hit();
        issue(2'd1, 8'd0, 16'h0077, 4'd5);
        checks++;
        if (nqr_push !== 1'b1 || nmc_qr_req.key !== 16'h0077) begin
            failures++;
            $display("FAIL query_push push=%b key=%h expected=1/0077", nqr_push, nmc_qr_req.key);
        end
        cycle();
        pulse_resp(1'b1, 16'h002A);
        exp_hit = exp_hit + 32'd1;
        checks++;
        if (resp_vld !== 1'b1 || resp_tag !== 4'd5 || resp_result !== 16'h002A || resp_found !== 1'b1) begin
            failures++;
            $display("FAIL query_resp vld=%b tag=%0d result=%h found=%b expected=1/5/002a/1",
                     resp_vld, resp_tag, resp_result, resp_found);
        end
        checks++;
        if (hit_cnt !== stat_exp(exp_hit) || miss_cnt !== stat_exp(exp_miss)) begin
            failures++;
            $display("FAIL query_hit_cnt hit=%0d miss=%0d expected=%0d/%0d",
                     hit_cnt, miss_cnt, stat_exp(exp_hit), stat_exp(exp_miss));
        end
        resp_rdy = 1'b1;
        cycle();
        resp_rdy = 1'b0;
        #1;
        checks++;
        if (resp_vld !== 1'b0) begin
            failures++;
            $display("FAIL query_pop vld=%b expected=0", resp_vld);
        end
    endtask

    task automatic test_fence();
        logic seen;
        issue(2'd1, 8'd0, 16'h0011, 4'd1);
        cycle();
        issue(2'd0, 8'd9, 16'h0, 4'd0);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (nwr_push !== 1'b0) seen = 1'b1;
            cycle();
        end
        nmc_qr_resp.valid = 1'b1;
        nmc_qr_resp.found = 1'b0;
        nmc_qr_resp.result = 16'h0011;
        #1;
        if (nwr_push !== 1'b0) seen = 1'b1;
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL fence_hold push_seen=%b expected=0", seen);
        end
        cycle();
        nmc_qr_resp = '0;
        exp_miss = exp_miss + 32'd1;
        #1;
        checks++;
        if (nwr_push !== 1'b1 || nmc_wr_req.addr !== 8'd9) begin
            failures++;
            $display("FAIL fence_release push=%b addr=%0d expected=1/9", nwr_push, nmc_wr_req.addr);
        end
        cycle();
        checks++;
        if (nwr_push !== 1'b0 || resp_tag !== 4'd1 || resp_found !== 1'b0 || resp_result !== 16'h0011) begin
            failures++;
            $display("FAIL fence_after push=%b tag=%0d found=%b result=%h expected=0/1/0/0011",
                     nwr_push, resp_tag, resp_found, resp_result);
        end
        resp_rdy = 1'b1;
        cycle();
        resp_rdy = 1'b0;
        #1;
    endtask

    task automatic test_credit();
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            issue(2'd1, 8'd0, 16'h0200 + 16'(i), 4'(i));
            if (nqr_push !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            failures++;
            $display("FAIL credit_first8 some_push_missing=%b expected=0", bad);
        end
        cycle();
        for (int i = 0; i < DEPTH; i++) begin
            nmc_qr_resp.valid = 1'b1;
            nmc_qr_resp.found = 1'b0;
            nmc_qr_resp.result = 16'h0100 + 16'(i);
            cycle();
        end
        nmc_qr_resp = '0;
        issue(2'd1, 8'd0, 16'h0208, 4'd8);
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (nqr_push !== 1'b0) bad = 1'b1;
            cycle();
        end
        checks++;
        if (bad !== 1'b0) begin
            failures++;
            $display("FAIL credit_ninth_blocked push_seen=%b expected=0", bad);
        end
        resp_rdy = 1'b1;
        #1;
        checks++;
        if (resp_vld !== 1'b1 || resp_tag !== 4'd0 || resp_result !== 16'h0100) begin
            failures++;
            $display("FAIL credit_head vld=%b tag=%0d result=%h expected=1/0/0100",
                     resp_vld, resp_tag, resp_result);
        end
        cycle();
        resp_rdy = 1'b0;
        #1;
        checks++;
        if (nqr_push !== 1'b1 || nmc_qr_req.key !== 16'h0208) begin
            failures++;
            $display("FAIL credit_ninth_push push=%b key=%h expected=1/0208", nqr_push, nmc_qr_req.key);
        end
        cycle();
        pulse_resp(1'b0, 16'h0108);
        exp_miss = exp_miss + 32'd9;
        bad = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            resp_rdy = 1'b1;
            #1;
            if (resp_vld !== 1'b1 || resp_tag !== 4'(i) || resp_result !== 16'h0100 + 16'(i)) begin
                bad = 1'b1;
                $display("FAIL credit_drain_%0d vld=%b tag=%0d result=%h expected=1/%0d/%h",
                         i, resp_vld, resp_tag, resp_result, i, 16'h0100 + 16'(i));
            end
            cycle();
        end
        resp_rdy = 1'b0;
        #1;
        checks++;
        if (bad !== 1'b0 || resp_vld !== 1'b0) begin
            failures++;
            $display("FAIL credit_drain_order bad=%b vld_after=%b expected=0/0", bad, resp_vld);
        end
        checks++;
        if (miss_cnt !== stat_exp(exp_miss)) begin
            failures++;
            $display("FAIL credit_miss_cnt got=%0d expected=%0d", miss_cnt, stat_exp(exp_miss));
        end
    endtask

    task automatic test_unexpected();
        checks++;
        if (err_unexp !== 1'b0) begin
            failures++;
            $display("FAIL unexp_before got=%b expected=0", err_unexp);
        end
        pulse_resp(1'b1, 16'h0055);
        checks++;
        if (err_unexp !== 1'b1 || resp_vld !== 1'b0) begin
            failures++;
            $display("FAIL unexp_flag err=%b vld=%b expected=1/0", err_unexp, resp_vld);
        end
        checks++;
        if (hit_cnt !== stat_exp(exp_hit) || miss_cnt !== stat_exp(exp_miss)) begin
            failures++;
            $display("FAIL unexp_counters hit=%0d miss=%0d expected=%0d/%0d",
                     hit_cnt, miss_cnt, stat_exp(exp_hit), stat_exp(exp_miss));
        end
    endtask

    task automatic test_flush();
        issue(2'd1, 8'd0, 16'h0003, 4'd3);
        issue(2'd1, 8'd0, 16'h0004, 4'd4);
        nmc_ready = 1'b1;
        issue(2'd2, 8'd0, 16'h0, 4'd0);
        checks++;
        if (flush_done !== 1'b0 || cmd_rdy !== 1'b0) begin
            failures++;
            $display("FAIL flush_wait done=%b rdy=%b expected=0/0", flush_done, cmd_rdy);
        end
        pulse_resp(1'b1, 16'h0033);
        checks++;
        if (flush_done !== 1'b0) begin
            failures++;
            $display("FAIL flush_one_left done=%b expected=0", flush_done);
        end
        pulse_resp(1'b1, 16'h0044);
        exp_hit = exp_hit + 32'd2;
        checks++;
        if (flush_done !== 1'b1) begin
            failures++;
            $display("FAIL flush_done_pulse done=%b expected=1", flush_done);
        end
        cycle();
        checks++;
        if (flush_done !== 1'b0 || cmd_rdy !== 1'b1 || resp_tag !== 4'd3) begin
            failures++;
            $display("FAIL flush_after done=%b rdy=%b head_tag=%0d expected=0/1/3",
                     flush_done, cmd_rdy, resp_tag);
        end
        // nmc busy holds off completion even with nothing outstanding
        nmc_ready = 1'b0;
        issue(2'd2, 8'd0, 16'h0, 4'd0);
        cycle();
        checks++;
        if (flush_done !== 1'b0) begin
            failures++;
            $display("FAIL flush_not_ready done=%b expected=0", flush_done);
        end
        nmc_ready = 1'b1;
        cycle();
        checks++;
        if (flush_done !== 1'b1) begin
            failures++;
            $display("FAIL flush_ready_done done=%b expected=1", flush_done);
        end
    endtask

    task automatic test_async_reset();
        issue(2'd1, 8'd0, 16'h0006, 4'd6);
        issue(2'd2, 8'd0, 16'h0, 4'd0);
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cmd_rdy, nwr_push, nqr_push, resp_vld, flush_done, err_unexp} !== 6'b0 ||
            hit_cnt !== '0 || miss_cnt !== '0) begin
            failures++;
            $display("FAIL reset_mid_flush outs=%b hit=%0d miss=%0d expected=000000/0/0",
                     {cmd_rdy, nwr_push, nqr_push, resp_vld, flush_done, err_unexp}, hit_cnt, miss_cnt);
        end
        #2;
        rst_n = 1'b1;
        cycle();
        checks++;
        if (cmd_rdy !== 1'b1 || resp_vld !== 1'b0) begin
            failures++;
            $display("FAIL reset_recover rdy=%b vld=%b expected=1/0", cmd_rdy, resp_vld);
        end
        // Outstanding query was discarded, so a late response is unexpected
        pulse_resp(1'b1, 16'h0066);
        checks++;
        if (err_unexp !== 1'b1 || resp_vld !== 1'b0 || hit_cnt !== '0) begin
            failures++;
            $display("FAIL reset_discard err=%b vld=%b hit=%0d expected=1/0/0", err_unexp, resp_vld, hit_cnt);
        end
        issue(2'd0, 8'd7, 16'h0, 4'd0);
        checks++;
        if (nwr_push !== 1'b1) begin
            failures++;
            $display("FAIL abort_setup push=%b expected=1", nwr_push);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (nwr_push !== 1'b0 || err_unexp !== 1'b0) begin
            failures++;
            $display("FAIL abort_push push=%b err=%b expected=0/0", nwr_push, err_unexp);
        end
        #2;
        rst_n = 1'b1;
        cycle();
        cycle();
    endtask

    initial begin
        test_reset();
        test_write();
        test_query_hit();
        test_fence();
        test_credit();
        test_unexpected();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout time=%0t limit=200000", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/nmc_initiator.md
Name: nmc_initiator

Overview:
- Host-side initiator for the nmc near-memory block. It accepts a unified command stream (write, query, flush) from the kernel control path and pushes nmc_wr_req_t / nmc_qr_req_t into the nmc request FIFOs.
- It collects every nmc_qr_resp_t pulse, tags it and buffers it for a valid/ready consumer.
- It enforces write/query ordering, which nmc does not guarantee because nmc services writes before queued queries.

Parameters:
TAG_W, 4, width of the per-query tag returned with each response
RESP_FIFO_DEPTH, 8, response buffer depth; also the query credit limit (power of 2)
CNT_W, 32, width of the statistics counters

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
cmd_vld  input  1  command valid
cmd_rdy  output  1  command accepted when cmd_vld&&cmd_rdy
cmd_op  input  2  0=WRITE, 1=QUERY, 2=FLUSH, 3=reserved (accepted, ignored)
cmd_wr  input  $bits(nmc_wr_req_t)  write payload
cmd_qr  input  $bits(nmc_qr_req_t)  query payload
cmd_tag  input  TAG_W  tag for QUERY
nmc_wr_req  output  $bits(nmc_wr_req_t)  to nmc
nwr_push  output  1  to nmc
nwr_full  input  1  from nmc
nmc_qr_req  output  $bits(nmc_qr_req_t)  to nmc
nqr_push  output  1  to nmc
nqr_full  input  1  from nmc
nmc_ready  input  1  nmc idle indication
nmc_qr_resp  input  $bits(nmc_qr_resp_t)  response; valid field is a 1-cycle pulse
resp_vld  output  1  buffered response valid
resp_rdy  input  1  consumer ready
resp_found  output  1  found flag
resp_result  output  $bits(nmc_qr_resp_t.result)  result
resp_tag  output  TAG_W  tag of the originating query
flush_done  output  1  1-cycle pulse when a FLUSH completes
err_unexp  output  1  sticky: response arrived with no query outstanding
hit_cnt  output  CNT_W  found responses (optional feature)
miss_cnt  output  CNT_W  not-found responses (optional feature)

Behaviour:
- Reset: state=IDLE, all pushes 0, cmd_rdy 0 while reset is asserted, resp_vld 0, flush_done 0, err_unexp 0, counters 0, outstanding=0, tag FIFO and response FIFO empty.
- cmd_rdy = (state==IDLE). On acceptance the payload and tag are latched into a command register.
- States:
  - IDLE: WRITE -> WR_FENCE; QUERY -> QR_PUSH; FLUSH -> FLUSH; reserved -> IDLE.
  - WR_FENCE: holds while outstanding!=0. Then it goes to WR_PUSH, or pushes directly if ~nwr_full.
  - WR_PUSH: nwr_push=1 in the first cycle with ~nwr_full, then -> IDLE. The earliest push is the cycle after acceptance.
  - QR_PUSH: nqr_push=1 when ~nqr_full && (outstanding + resp_fifo_count) < RESP_FIFO_DEPTH. On push, the tag is written into the tag FIFO, outstanding++, and the state returns to IDLE.
  - FLUSH: waits for outstanding==0 && nmc_ready && ~nwr_full-pending. It then pulses flush_done for 1 cycle and returns to IDLE. The response FIFO need not be drained.
- Pushes are single-cycle. nmc_wr_req / nmc_qr_req are driven from the command register and are stable while a push is pending.
- Response capture:
  - nmc_qr_resp.valid pulse: pop the tag FIFO, outstanding--, write {found, result, tag} into the response FIFO.
  - This path is never stalled. The credit rule guarantees a free slot.
  - A push and a response in the same cycle leave outstanding unchanged.
- Response with outstanding==0: the response is dropped, err_unexp is set (sticky until reset), and counters are not updated.
- Response FIFO is first-word-fall-through: resp_vld = ~empty. It pops on resp_vld&&resp_rdy. A write and a pop in the same cycle are legal when full.
- Responses are delivered in query issue order.
- Asynchronous reset mid-operation aborts any pending push immediately, with no partial push. Outstanding tags are discarded.

Optional Feature:
- Macro NMC_INITIATOR_STATS_EN.
- Defined: hit_cnt increments on each captured found=1 response and miss_cnt on each found=0 response. Both saturate at all-ones and are reset by rst_n.
- Undefined: no counter flops are built, and hit_cnt/miss_cnt are tied to 0.

Test Plan:
- WRITE addr=3 with nwr_full=0 -> nwr_push is high exactly 1 cycle, 1 cycle after acceptance, with nmc_wr_req.addr=3; cmd_rdy returns high the next cycle.
- QUERY tag=5, then nmc_qr_resp{valid=1,found=1,result=0x2A} -> resp_vld=1, resp_tag=5, resp_result=0x2A, hit_cnt=1.
- QUERY tag=1, then WRITE before the response -> nwr_push stays 0 until the response for tag 1 is captured, then pushes on the following cycle.
- resp_rdy=0; issue 9 queries with RESP_FIFO_DEPTH=8 -> the 9th nqr_push stays 0 until one response is popped; no response is lost.
- Response pulse with nothing outstanding -> err_unexp=1, resp_vld stays 0, and miss_cnt/hit_cnt are unchanged.
- FLUSH with 2 queries outstanding -> flush_done pulses 1 cycle after the 2nd response when nmc_ready=1; assert rst_n low mid-flush -> all outputs return to their reset values asynchronously.
